// File: rtl/store_write_buffer.sv
// Store write buffer: formats sw/sh/sb into word address, lane data and byte enables, queues them and drains over req/ack.
// Entries reach mem_* one cycle after acceptance; st_ready drops when full, with no bypass from a same-cycle ack.
module store_write_buffer #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic [1:0]       st_type,
   output logic             st_exc,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ack,
   input  logic [31:0]      ld_addr,
   output logic             ld_conflict,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  be;
   } entry_t;

   entry_t           ent_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;

   entry_t fmt;
   logic   aligned;
   logic   accept;
   logic   push;
   logic   pop;

   always_comb begin
      fmt       = '0;
      fmt.waddr = st_addr[31:2];
      aligned   = 1'b1;
      case (st_type)
         2'b00: begin
            aligned  = (st_addr[1:0] == 2'b00);
            fmt.be   = 4'b1111;
            fmt.data = st_data;
         end
         2'b01: begin
            aligned = ~st_addr[0];
            if (st_addr[1]) begin
               fmt.be   = 4'b1100;
               fmt.data = {st_data[15:0], 16'h0};
            end else begin
               fmt.be   = 4'b0011;
               fmt.data = {16'h0, st_data[15:0]};
            end
         end
         2'b10: begin
            fmt.be   = 4'b0001 << st_addr[1:0];
            fmt.data = {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
         end
         default: ;
      endcase
   end

   assign st_ready = (count < FULL_CNT);
   assign accept   = st_valid & st_ready;
   assign push     = accept & (st_type != 2'b11) & aligned;
   assign empty    = (count == '0);
   assign mem_req  = ~empty;
   assign pop      = mem_req & mem_ack;

   assign mem_addr  = mem_req ? {ent_q[head_q].waddr, 2'b00} : 32'h0;
   assign mem_wdata = mem_req ? ent_q[head_q].data : 32'h0;
   assign mem_be    = mem_req ? ent_q[head_q].be : 4'h0;

   // An entry being popped this cycle stays valid until the edge, so it still blocks loads.
   always_comb begin
      ld_conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (ent_q[i].waddr == ld_addr[31:2])) ld_conflict = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         head_q <= '0;
         tail_q <= '0;
         vld_q  <= '0;
         st_exc <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         st_exc <= accept & (st_type != 2'b11) & ~aligned;
         if (push) begin
            ent_q[tail_q] <= fmt;
            vld_q[tail_q] <= 1'b1;
            tail_q        <= tail_q + 1'b1;
         end
         if (pop) begin
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: formatting table, directed corner sequences and a randomized run against a queue model.
module tb_store_write_buffer;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;

   logic             clk;
   logic             reset;
   logic             st_valid;
   logic             st_ready;
   logic [31:0]      st_addr;
   logic [31:0]      st_data;
   logic [1:0]       st_type;
   logic             st_exc;
   logic             mem_req;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_be;
   logic             mem_ack;
   logic [31:0]      ld_addr;
   logic             ld_conflict;
   logic [CNT_W-1:0] count;
   logic             empty;

   int checks   = 0;
   int failures = 0;

   store_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .st_exc(st_exc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
      .count(count), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
      st_type  = t;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      mem_ack = 1'b0;
      ld_addr = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc();
   endtask

   // Reference model: a queue of formatted stores built from the lane rules.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ment_t;

   ment_t q[$];
   logic  exc_m;

   function automatic logic m_aligned(input logic [31:0] a, input logic [1:0] t);
      if (t == 2'd0) return (a % 4) == 0;
      if (t == 2'd1) return (a % 2) == 0;
      return 1'b1;
   endfunction

   function automatic ment_t m_fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
      ment_t  e;
      int     off;
      logic [31:0] mask;
      int     be;
      off = int'(a % 4);
      case (t)
         2'd0:    begin mask = 32'hFFFF_FFFF; be = 15; end
         2'd1:    begin mask = 32'h0000_FFFF; be = 3 << off; end
         default: begin mask = 32'h0000_00FF; be = 1 << off; end
      endcase
      e.addr = a - off;
      e.data = (d & mask) << (8 * off);
      e.be   = be[3:0];
      return e;
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  typ;
      logic        exc;
      logic        req;
      logic [3:0]  be;
      logic [31:0] wdata;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{32'h4001, 32'hDEADBEEF, 2'd0, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[1]  = '{32'h4003, 32'h1234BEEF, 2'd1, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[2]  = '{32'h4001, 32'h0000005A, 2'd2, 1'b0, 1'b1, 4'h2, 32'h00005A00};
      tbl[3]  = '{32'h4000, 32'hCAFEF00D, 2'd0, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D};
      tbl[4]  = '{32'h4000, 32'h1234BEEF, 2'd1, 1'b0, 1'b1, 4'h3, 32'h0000BEEF};
      tbl[5]  = '{32'h4002, 32'h1234BEEF, 2'd1, 1'b0, 1'b1, 4'hC, 32'hBEEF0000};
      tbl[6]  = '{32'h4001, 32'h1234BEEF, 2'd1, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[7]  = '{32'h4002, 32'hCAFEF00D, 2'd0, 1'b1, 1'b0, 4'h0, 32'h0};
      tbl[8]  = '{32'h4002, 32'hFFFFFF77, 2'd2, 1'b0, 1'b1, 4'h4, 32'h00770000};
      tbl[9]  = '{32'h4001, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b0, 4'h0, 32'h0};
      tbl[10] = '{32'h4000, 32'h123456C3, 2'd2, 1'b0, 1'b1, 4'h1, 32'h000000C3};

      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      mem_ack = 1'b0;
      ld_addr = 32'h0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_exc", st_exc, 0);
      chk("rst_conflict", ld_conflict, 0);
      chk("rst_ready", st_ready, 1);
      do_reset();

      // sb to the top byte lane
      drive(1'b1, 32'h1003, 32'h000000AB, 2'd2);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      chk("sb_req", mem_req, 1);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_be", mem_be, 4'b1000);
      chk("sb_wdata", mem_wdata, 32'hAB000000);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("sb_drained", empty, 1);

      // fill to full, then ack while full must not admit a new store
      drive(1'b1, 32'h2002, 32'h1234BEEF, 2'd1);
      cyc();
      drive(1'b1, 32'h3000, 32'hDEADBEEF, 2'd0);
      cyc();
      drive(1'b1, 32'h6000, 32'h11111111, 2'd0);
      #1;
      chk("full_head_be", mem_be, 4'b1100);
      chk("full_head_wdata", mem_wdata, 32'hBEEF0000);
      chk("full_count", count, 2);
      chk("full_ready", st_ready, 0);
      cyc();
      chk("full_no_accept", count, 2);
      mem_ack = 1'b1;
      #1;
      chk("full_ack_ready", st_ready, 0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      chk("pop1_count", count, 1);
      chk("pop1_addr", mem_addr, 32'h3000);
      chk("pop1_wdata", mem_wdata, 32'hDEADBEEF);
      cyc();
      mem_ack = 1'b0;
      chk("pop2_empty", empty, 1);

      // lane formatting and misalignment table
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, tbl[i].addr, tbl[i].data, tbl[i].typ);
         cyc();
         drive(1'b0, 32'h0, 32'h0, 2'b11);
         chk($sformatf("tbl%0d_exc", i), st_exc, tbl[i].exc);
         chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].req);
         chk($sformatf("tbl%0d_be", i), mem_be, tbl[i].be);
         chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].wdata);
         chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].req ? 32'h4000 : 32'h0);
         mem_ack = tbl[i].req;
         cyc();
         mem_ack = 1'b0;
         chk($sformatf("tbl%0d_exc_drop", i), st_exc, 0);
         chk($sformatf("tbl%0d_empty", i), empty, 1);
      end

      // load conflict, including the cycle the entry is popped
      drive(1'b1, 32'h5004, 32'h01020304, 2'd0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      ld_addr = 32'h5006;
      #1;
      chk("conf_hit", ld_conflict, 1);
      ld_addr = 32'h5008;
      #1;
      chk("conf_miss", ld_conflict, 0);
      ld_addr = 32'h5006;
      mem_ack = 1'b1;
      #1;
      chk("conf_popping", ld_conflict, 1);
      cyc();
      mem_ack = 1'b0;
      chk("conf_after_pop", ld_conflict, 0);

      // push and pop together with one entry, wrapping the pointers
      drive(1'b1, 32'h7000, 32'h0, 2'd0);
      cyc();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 32'h7000 + 4 * i, i, 2'd0);
         mem_ack = 1'b1;
         #1;
         chk($sformatf("wrap%0d_ready", i), st_ready, 1);
         cyc();
         chk($sformatf("wrap%0d_count", i), count, 1);
         chk($sformatf("wrap%0d_addr", i), mem_addr, 32'h7000 + 4 * i);
         chk($sformatf("wrap%0d_wdata", i), mem_wdata, i);
      end
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      cyc();
      mem_ack = 1'b0;
      chk("wrap_drained", empty, 1);

      // reset mid-cycle with two queued entries
      drive(1'b1, 32'h9000, 32'hAAAA5555, 2'd0);
      cyc();
      drive(1'b1, 32'h9004, 32'h5555AAAA, 2'd0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 2'b11);
      chk("pre_rst_count", count, 2);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_addr", mem_addr, 0);
      #1;
      reset = 1'b0;
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("post_rst_count", count, 0);
      chk("post_rst_req", mem_req, 0);
      chk("post_rst_ready", st_ready, 1);

      // randomized run against the queue model
      do_reset();
      q.delete();
      exc_m = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         ment_t exp_h;
         logic  exp_conf;
         logic  acc;
         st_valid = ($urandom_range(0, 3) != 0);
         st_type  = 2'($urandom_range(0, 3));
         st_addr  = 32'h8000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
         st_data  = $urandom;
         mem_ack  = ($urandom_range(0, 2) == 0);
         ld_addr  = 32'h8000 + ($urandom_range(0, 4) << 2) + $urandom_range(0, 3);
         #1;
         exp_h = '{32'h0, 32'h0, 4'h0};
         if (q.size() > 0) exp_h = q[0];
         exp_conf = 1'b0;
         foreach (q[k]) if ((q[k].addr >> 2) == (ld_addr >> 2)) exp_conf = 1'b1;
         chk("rnd_ready", st_ready, q.size() < DEPTH);
         chk("rnd_count", count, q.size());
         chk("rnd_empty", empty, q.size() == 0);
         chk("rnd_req", mem_req, q.size() != 0);
         chk("rnd_addr", mem_addr, exp_h.addr);
         chk("rnd_wdata", mem_wdata, exp_h.data);
         chk("rnd_be", mem_be, exp_h.be);
         chk("rnd_exc", st_exc, exc_m);
         chk("rnd_conflict", ld_conflict, exp_conf);
         acc = st_valid && (q.size() < DEPTH);
         if (q.size() > 0 && mem_ack) void'(q.pop_front());
         if (acc && st_type != 2'd3 && m_aligned(st_addr, st_type))
            q.push_back(m_fmt(st_addr, st_data, st_type));
         exc_m = acc && st_type != 2'd3 && !m_aligned(st_addr, st_type);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
